// File: rtl/systola_pkg.sv
// Shared widths and types for the systolic compute rows.
package systola_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 12;
    localparam int unsigned N  = 4;

    typedef logic [DW-1:0] data_t;
    typedef logic [OW-1:0] acc_t;

endpackage

// File: rtl/pe_mac_cell.sv
// One weight-stationary MAC processing element with a registered activation pass-through.
module pe_mac_cell #(
    parameter int unsigned DW = systola_pkg::DW,
    parameter int unsigned OW = systola_pkg::OW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] a_in,
    output logic [DW-1:0] a_out,
    output logic [OW-1:0] acc
);
    import systola_pkg::*;

    logic [2*DW-1:0] w_prod;
    logic [DW-1:0]   r_a;
    logic [OW-1:0]   r_acc;

    // Full-width unsigned product; only the low OW bits reach the accumulator.
    always_comb begin
        w_prod = w * a_in;
    end

    // Accumulate and shift the activation on enabled edges; hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a   <= '0;
            r_acc <= '0;
        end else if (en) begin
            r_a   <= a_in;
            r_acc <= r_acc + w_prod[OW-1:0];
        end
    end

    assign a_out = r_a;
    assign acc   = r_acc;

endmodule

// File: rtl/pe_lin_gen.sv
// Linear weight-stationary systolic row of N MAC cells sharing one activation stream.
module pe_lin_gen #(
    parameter int unsigned N  = systola_pkg::N,
    parameter int unsigned DW = systola_pkg::DW,
    parameter int unsigned OW = systola_pkg::OW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fire,
    input  logic [DW-1:0] in_w [0:N-1],
    input  logic [DW-1:0] in_a,
    output logic [OW-1:0] outs [0:N-1]
);
    import systola_pkg::*;

    // w_op[i] is the operand of PE i: in_a for PE0, previous cell's a_out otherwise.
    logic [DW-1:0] w_op [0:N-1];

    assign w_op[0] = in_a;

    for (genvar gi = 0; gi < N; gi++) begin : g_pe
        if (gi < N - 1) begin : g_mid
            pe_mac_cell #(
                .DW (DW),
                .OW (OW)
            ) u_cell (
                .clk   (clk),
                .rstn  (rstn),
                .en    (fire),
                .w     (in_w[gi]),
                .a_in  (w_op[gi]),
                .a_out (w_op[gi+1]),
                .acc   (outs[gi])
            );
        end else begin : g_last
            // The last cell's pass-through has no consumer.
            logic [DW-1:0] w_a_unused;
            pe_mac_cell #(
                .DW (DW),
                .OW (OW)
            ) u_cell (
                .clk   (clk),
                .rstn  (rstn),
                .en    (fire),
                .w     (in_w[gi]),
                .a_in  (w_op[gi]),
                .a_out (w_a_unused),
                .acc   (outs[gi])
            );
        end
    end

endmodule

// File: tb/tb_pe_lin_gen.sv
// Directed self-checking bench for the pe_lin_gen systolic row.
module tb_pe_lin_gen;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 12;

    logic          clk;
    logic          rstn;
    logic          fire;
    logic [DW-1:0] in_w [0:N-1];
    logic [DW-1:0] in_a;
    logic [OW-1:0] outs [0:N-1];

    int unsigned n_total;
    int unsigned n_bad;

    pe_lin_gen #(
        .N  (N),
        .DW (DW),
        .OW (OW)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .fire (fire),
        .in_w (in_w),
        .in_a (in_a),
        .outs (outs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int unsigned e0, input int unsigned e1,
                            input int unsigned e2, input int unsigned e3);
        chk($sformatf("%s[0]", tag), 32'(outs[0]), e0);
        chk($sformatf("%s[1]", tag), 32'(outs[1]), e1);
        chk($sformatf("%s[2]", tag), 32'(outs[2]), e2);
        chk($sformatf("%s[3]", tag), 32'(outs[3]), e3);
    endtask

    // One clock edge, then sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int unsigned w0, input int unsigned w1,
                         input int unsigned w2, input int unsigned w3);
        in_w[0] = DW'(w0);
        in_w[1] = DW'(w1);
        in_w[2] = DW'(w2);
        in_w[3] = DW'(w3);
    endtask

    // Short reset pulse placed mid-cycle, checking the clear while still low.
    task automatic rst_pulse(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        chk_outs(tag, 0, 0, 0, 0);
        #2;
        rstn = 1'b1;
    endtask

    task automatic run_stream();
        set_w(0, 1, 2, 3);
        fire = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_a = DW'(k);
            tick();
            if (k == 1) chk_outs("stream1", 0, 0, 0, 0);
            if (k == 2) chk_outs("stream2", 0, 1, 0, 0);
        end
        chk_outs("stream8", 0, 28, 42, 45);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rstn    = 1'b0;
        fire    = 1'b1;
        in_a    = 8'd1;
        set_w(0, 1, 2, 3);

        // Reset held with fire active: nothing accumulates.
        tick();
        chk_outs("rst_hold1", 0, 0, 0, 0);
        tick();
        tick();
        chk_outs("rst_hold3", 0, 0, 0, 0);
        #3;
        rstn = 1'b1;

        // Stream 1..8 through w={0,1,2,3}.
        run_stream();

        // Stall: nothing moves while fire is low.
        fire = 1'b0;
        in_a = 8'd0;
        for (int k = 0; k < 8; k++) tick();
        chk_outs("stall", 0, 28, 42, 45);

        // Resume: pipeline still holds 8,7,6 for PE1..PE3.
        fire = 1'b1;
        tick();
        chk_outs("resume", 0, 36, 56, 63);

        // Asynchronous clear mid-cycle, then confirm the pipeline was cleared too.
        rst_pulse("rst_mid");
        chk_outs("rst_after", 0, 0, 0, 0);
        in_a = 8'd5;
        tick();
        chk_outs("post_rst1", 0, 0, 0, 0);
        in_a = 8'd0;
        tick();
        chk_outs("post_rst2", 0, 5, 0, 0);

        // Stream again, then a mid-stream reset pulse.
        rst_pulse("rst_pre_stream");
        run_stream();
        rst_pulse("rst_stream");
        in_a = 8'd5;
        tick();
        chk_outs("rs_next1", 0, 0, 0, 0);
        in_a = 8'd0;
        tick();
        chk_outs("rs_next2", 0, 5, 0, 0);

        // Wrap-around of the 12-bit accumulator.
        rst_pulse("rst_wrap");
        set_w(255, 0, 0, 0);
        in_a = 8'd255;
        tick();
        chk("wrap1", 32'(outs[0]), 3585);
        tick();
        chk("wrap2", 32'(outs[0]), 3074);

        // Weight change mid-stream.
        rst_pulse("rst_wchg");
        set_w(1, 1, 1, 1);
        in_a = 8'd2;
        for (int k = 0; k < 4; k++) tick();
        chk_outs("wchg4", 8, 6, 4, 2);
        set_w(0, 0, 0, 0);
        tick();
        tick();
        chk_outs("wzero", 8, 6, 4, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
